// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / load-use hazard controller.
// Optional build macro used by the top: HAZ_PERF_CNT_EN.
package fwd_hazard_ctrl_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned SEL_W  = 2;

   localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
   localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;
   localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b10;

   // Register-write record carried by every shadow stage.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } wr_slot_t;

   // EX stage additionally remembers which sources it reads.
   typedef struct packed {
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              use_rs;
      logic              use_rt;
      wr_slot_t          wr;
   } ex_slot_t;

   typedef enum logic {RUN, LSTALL} haz_state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Priority compare for one EX operand: newest matching writer (MEM) beats WB.
module fwd_sel_logic
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  logic              use_src,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_we,
   output logic [SEL_W-1:0]  sel
);

   // Register 0 is hard-wired, so it is never a forwarding source.
   always_comb begin
      sel = SEL_RF;
      if (use_src && (src != '0)) begin
         if (mem_we && (mem_rd == src)) begin
            sel = SEL_EXMEM;
         end else if (wb_we && (wb_rd == src)) begin
            sel = SEL_MEMWB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX/MEM/WB shadow pipeline driving operand forwarding and load-use stalls.
// Define HAZ_PERF_CNT_EN to add the saturating stall_cnt output.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_en,
   input  logic              flush,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   output logic [SEL_W-1:0]  fwd_a_sel,
   output logic [SEL_W-1:0]  fwd_b_sel,
   output logic              stall,
   output logic              idex_bubble,
   output logic              wb_valid
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   ex_slot_t   ex_q;
   wr_slot_t   mem_q;
   wr_slot_t   wb_q;
   ex_slot_t   ex_d;
   haz_state_t state_q;
   haz_state_t state_d;
   logic       load_use;

   assign load_use = ex_q.wr.memread && (ex_q.wr.rd != '0) &&
                     (((ex_q.wr.rd == id_rs) && id_use_rs) ||
                      ((ex_q.wr.rd == id_rt) && id_use_rt));

   // Hazard FSM; flush wins over a load-use stall and cancels a pending one.
   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      idex_bubble = 1'b0;
      case (state_q)
         RUN: begin
            stall       = load_use && !flush;
            idex_bubble = stall;
            if (stall && pipe_en) begin
               state_d = LSTALL;
            end
         end
         LSTALL: begin
            if (pipe_en || flush) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      ex_d = ex_slot_t'('0);
      if (!(stall || flush)) begin
         ex_d.rs          = id_rs;
         ex_d.rt          = id_rt;
         ex_d.use_rs      = id_use_rs;
         ex_d.use_rt      = id_use_rt;
         ex_d.wr.rd       = id_rd;
         ex_d.wr.regwrite = id_regwrite;
         ex_d.wr.memread  = id_memread;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         ex_q    <= ex_slot_t'('0);
         mem_q   <= wr_slot_t'('0);
         wb_q    <= wr_slot_t'('0);
      end else begin
         state_q <= state_d;
         if (pipe_en) begin
            ex_q  <= ex_d;
            mem_q <= ex_q.wr;
            wb_q  <= mem_q;
         end
      end
   end

   fwd_sel_logic u_sel_a (
      .src     (ex_q.rs),
      .use_src (ex_q.use_rs),
      .mem_rd  (mem_q.rd),
      .mem_we  (mem_q.regwrite),
      .wb_rd   (wb_q.rd),
      .wb_we   (wb_q.regwrite),
      .sel     (fwd_a_sel)
   );

   fwd_sel_logic u_sel_b (
      .src     (ex_q.rt),
      .use_src (ex_q.use_rt),
      .mem_rd  (mem_q.rd),
      .mem_we  (mem_q.regwrite),
      .wb_rd   (wb_q.rd),
      .wb_we   (wb_q.regwrite),
      .sel     (fwd_b_sel)
   );

   assign wb_valid = wb_q.regwrite && (wb_q.rd != '0);

   // A load always writes a register; a lone memread flag means a decode fault.
   a_mem_load_writes: assert property (@(posedge clk) disable iff (rst)
      mem_q.memread |-> mem_q.regwrite);
   a_wb_load_writes: assert property (@(posedge clk) disable iff (rst)
      wb_q.memread |-> wb_q.regwrite);

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'd0;
      end else if (stall && pipe_en && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
